// File: rtl/huff_decoder.sv
// Bit-serial Huffman decoder: char_valid rises 1 cycle after a code's last bit; bit_ready drops while a char is stalled.
// Optional HUFF_DEC_SYMCNT_EN adds sym_count, a wrapping count of delivered characters.
module huff_decoder #(
  parameter int N      = 3,
  parameter int CODE_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       table_load,
  input  logic [N-1:0][7:0]          tbl_char,
  input  logic [N-1:0][CODE_W-1:0]   tbl_value,
  input  logic [N-1:0][CODE_W-1:0]   tbl_mask,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic [7:0]                 char_out,
  output logic                       char_valid,
  input  logic                       char_ready,
  output logic                       err,
  output logic                       table_valid
`ifdef HUFF_DEC_SYMCNT_EN
  ,
  output logic [7:0]                 sym_count
`endif
);

  localparam int LEN_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t                     state_q, state_d;
  logic [CODE_W-1:0]          acc_q, acc_d, acc_n;
  logic [LEN_W-1:0]           len_q, len_d, len_n;
  logic [7:0]                 char_out_q, char_out_d;
  logic                       char_valid_q, char_valid_d;
  logic                       err_q, err_d;
  logic                       table_valid_q, table_valid_d;
  logic [N-1:0][7:0]          char_tbl_q, char_tbl_d;
  logic [N-1:0][CODE_W-1:0]   value_tbl_q, value_tbl_d;
  logic [N-1:0][CODE_W-1:0]   mask_tbl_q, mask_tbl_d;
  logic                       hit;
  logic [7:0]                 hit_char;
`ifdef HUFF_DEC_SYMCNT_EN
  logic [7:0]                 sym_count_q, sym_count_d;
`endif

  function automatic logic [LEN_W-1:0] popcnt(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < CODE_W; b++) cnt = cnt + LEN_W'(m[b]);
    return cnt;
  endfunction

  // Depends only on registered state and char_ready, never on bit_valid.
  assign bit_ready = (state_q == RUN) && (!char_valid_q || char_ready);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    len_d         = len_q;
    char_out_d    = char_out_q;
    char_valid_d  = char_valid_q;
    err_d         = err_q;
    table_valid_d = table_valid_q;
    char_tbl_d    = char_tbl_q;
    value_tbl_d   = value_tbl_q;
    mask_tbl_d    = mask_tbl_q;
`ifdef HUFF_DEC_SYMCNT_EN
    sym_count_d   = sym_count_q;
`endif
    acc_n         = {acc_q[CODE_W-2:0], bit_in};
    len_n         = len_q + LEN_W'(1);
    hit           = 1'b0;
    hit_char      = '0;

    // Ascending scan with a found flag gives lowest-index priority.
    for (int i = 0; i < N; i++) begin
      if (!hit && (mask_tbl_q[i] != '0) && (popcnt(mask_tbl_q[i]) == len_n) &&
          ((acc_n & mask_tbl_q[i]) == (value_tbl_q[i] & mask_tbl_q[i]))) begin
        hit      = 1'b1;
        hit_char = char_tbl_q[i];
      end
    end

    if (char_valid_q && char_ready) begin
      char_valid_d = 1'b0;
`ifdef HUFF_DEC_SYMCNT_EN
      sym_count_d  = sym_count_q + 8'd1;
`endif
    end

    if (table_load) begin
      char_tbl_d    = tbl_char;
      value_tbl_d   = tbl_value;
      mask_tbl_d    = tbl_mask;
      acc_d         = '0;
      len_d         = '0;
      err_d         = 1'b0;
      char_valid_d  = 1'b0;
      table_valid_d = 1'b1;
      state_d       = RUN;
`ifdef HUFF_DEC_SYMCNT_EN
      sym_count_d   = '0;
`endif
    end else if (bit_valid && bit_ready) begin
      if (hit) begin
        char_out_d   = hit_char;
        char_valid_d = 1'b1;
        acc_d        = '0;
        len_d        = '0;
      end else if (len_n == LEN_W'(CODE_W)) begin
        err_d   = 1'b1;
        state_d = ERR;
      end else begin
        acc_d = acc_n;
        len_d = len_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      len_q         <= '0;
      char_out_q    <= '0;
      char_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      table_valid_q <= 1'b0;
`ifdef HUFF_DEC_SYMCNT_EN
      sym_count_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      char_out_q    <= char_out_d;
      char_valid_q  <= char_valid_d;
      err_q         <= err_d;
      table_valid_q <= table_valid_d;
      char_tbl_q    <= char_tbl_d;
      value_tbl_q   <= value_tbl_d;
      mask_tbl_q    <= mask_tbl_d;
`ifdef HUFF_DEC_SYMCNT_EN
      sym_count_q   <= sym_count_d;
`endif
    end
  end

  assign char_out    = char_out_q;
  assign char_valid  = char_valid_q;
  assign err         = err_q;
  assign table_valid = table_valid_q;
`ifdef HUFF_DEC_SYMCNT_EN
  assign sym_count   = sym_count_q;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Bench for huff_decoder: directed scenarios, a vector table, and random streams against a queue model.
module tb_huff_decoder;

  logic             clk = 1'b0;
  logic             reset;
  logic             table_load;
  logic [2:0][7:0]  tbl_char;
  logic [2:0][2:0]  tbl_value;
  logic [2:0][2:0]  tbl_mask;
  logic             bit_in, bit_valid, bit_ready;
  logic [7:0]       char_out;
  logic             char_valid, char_ready;
  logic             err, table_valid;
`ifdef HUFF_DEC_SYMCNT_EN
  logic [7:0]       sym_count;
`endif

  always #5 clk = ~clk;

  huff_decoder #(.N(3), .CODE_W(3)) dut (
    .clk(clk), .reset(reset), .table_load(table_load),
    .tbl_char(tbl_char), .tbl_value(tbl_value), .tbl_mask(tbl_mask),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .err(err), .table_valid(table_valid)
`ifdef HUFF_DEC_SYMCNT_EN
    , .sym_count(sym_count)
`endif
  );

  typedef struct {
    logic [2:0][7:0] c;
    logic [2:0][2:0] v;
    logic [2:0][2:0] m;
  } tbl_t;

  typedef struct {
    int         tsel;
    logic [2:0] bits;
    int         nbits;
    logic       exp_vld;
    logic [7:0] exp_char;
    logic       exp_err;
  } vec_t;

  tbl_t       tbls[4];
  vec_t       vecs[12];
  logic       bq[$];
  logic [7:0] expq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int t, input int i, input logic [7:0] c,
                           input logic [2:0] v, input logic [2:0] m);
    tbls[t].c[i] = c;
    tbls[t].v[i] = v;
    tbls[t].m[i] = m;
  endtask

  task automatic load(input int t);
    tbl_char   = tbls[t].c;
    tbl_value  = tbls[t].v;
    tbl_mask   = tbls[t].m;
    table_load = 1'b1;
    cyc();
    table_load = 1'b0;
  endtask

  // Code bits come straight from the table: length = ones in mask, MSB of code first.
  task automatic push_code(input int t, input int i);
    int len;
    len = $countones(tbls[t].m[i]);
    for (int b = len - 1; b >= 0; b--) bq.push_back(tbls[t].v[i][b]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s2[5];
    logic e2[5];
    logic [7:0] c2[5];
    int budget;
    logic acc_now, take_now;

    set_entry(0, 0, 8'h61, 3'b000, 3'b001);
    set_entry(0, 1, 8'h62, 3'b010, 3'b011);
    set_entry(0, 2, 8'h63, 3'b011, 3'b011);
    set_entry(1, 0, 8'h78, 3'b000, 3'b111);
    set_entry(1, 1, 8'h79, 3'b001, 3'b111);
    set_entry(1, 2, 8'h7a, 3'b010, 3'b111);
    set_entry(2, 0, 8'h75, 3'b000, 3'b000);
    set_entry(2, 1, 8'h70, 3'b001, 3'b001);
    set_entry(2, 2, 8'h71, 3'b001, 3'b001);
    set_entry(3, 0, 8'h70, 3'b001, 3'b001);
    set_entry(3, 1, 8'h71, 3'b001, 3'b011);
    set_entry(3, 2, 8'h72, 3'b000, 3'b011);

    vecs[0]  = '{0, 3'b000, 1, 1'b1, 8'h61, 1'b0};
    vecs[1]  = '{0, 3'b010, 2, 1'b1, 8'h62, 1'b0};
    vecs[2]  = '{0, 3'b011, 2, 1'b1, 8'h63, 1'b0};
    vecs[3]  = '{1, 3'b000, 3, 1'b1, 8'h78, 1'b0};
    vecs[4]  = '{1, 3'b001, 3, 1'b1, 8'h79, 1'b0};
    vecs[5]  = '{1, 3'b010, 3, 1'b1, 8'h7a, 1'b0};
    vecs[6]  = '{1, 3'b011, 3, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1, 3'b111, 3, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{2, 3'b001, 1, 1'b1, 8'h70, 1'b0};
    vecs[9]  = '{2, 3'b000, 3, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{3, 3'b001, 2, 1'b1, 8'h71, 1'b0};
    vecs[11] = '{3, 3'b000, 2, 1'b1, 8'h72, 1'b0};

    reset = 1'b1; table_load = 1'b0; bit_in = 1'b1; bit_valid = 1'b1; char_ready = 1'b0;
    tbl_char = '0; tbl_value = '0; tbl_mask = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_table_valid", table_valid, 0);
    chk("rst_char_out", char_out, 0);
    bit_valid = 1'b0;

    // Back-to-back stream 1,0,0,1,1 -> b, a, c
    s2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    e2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    c2 = '{8'h00, 8'h62, 8'h61, 8'h00, 8'h63};
    char_ready = 1'b1;
    load(0);
    chk("load_table_valid", table_valid, 1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("stream_bit_ready%0d", j), bit_ready, 1);
      bit_valid = 1'b1; bit_in = s2[j];
      cyc();
      chk($sformatf("stream_valid%0d", j), char_valid, e2[j]);
      if (e2[j]) chk($sformatf("stream_char%0d", j), char_out, c2[j]);
      chk($sformatf("stream_err%0d", j), err, 0);
    end
    bit_valid = 1'b0;

    // Stall with char_ready low
    char_ready = 1'b0;
    load(0);
    bit_valid = 1'b1; bit_in = 1'b1; cyc();
    bit_in = 1'b0; cyc();
    chk("stall_valid", char_valid, 1);
    chk("stall_char", char_out, 8'h62);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("stall_bit_ready%0d", j), bit_ready, 0);
      cyc();
      chk($sformatf("stall_hold_valid%0d", j), char_valid, 1);
      chk($sformatf("stall_hold_char%0d", j), char_out, 8'h62);
    end
    bit_valid = 1'b0; char_ready = 1'b1;
    #1;
    chk("stall_release_bit_ready", bit_ready, 1);
    cyc();
    chk("stall_after_valid", char_valid, 0);
    chk("stall_after_bit_ready", bit_ready, 1);

    // Bad code stream 1,1,1 then reload
    load(1);
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk($sformatf("bad_err%0d", j), err, (j == 2) ? 1 : 0);
      chk($sformatf("bad_valid%0d", j), char_valid, 0);
    end
    chk("bad_bit_ready", bit_ready, 0);
    cyc();
    chk("bad_err_sticky", err, 1);
    bit_valid = 1'b0;
    load(1);
    chk("reload_err", err, 0);
    chk("reload_bit_ready", bit_ready, 1);

    // Load mid-symbol discards the partial code
    load(0);
    bit_valid = 1'b1; bit_in = 1'b1; cyc();
    bit_valid = 1'b0;
    load(0);
    bit_valid = 1'b1; bit_in = 1'b0; cyc();
    bit_valid = 1'b0;
    chk("midload_valid", char_valid, 1);
    chk("midload_char", char_out, 8'h61);

    // Vector table
    char_ready = 1'b1;
    foreach (vecs[i]) begin
      load(vecs[i].tsel);
      for (int k = 0; k < vecs[i].nbits; k++) begin
        bit_valid = 1'b1; bit_in = vecs[i].bits[vecs[i].nbits - 1 - k];
        cyc();
        if (k < vecs[i].nbits - 1) chk($sformatf("vec%0d_mid_valid%0d", i, k), char_valid, 0);
      end
      bit_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), char_valid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_char", i), char_out, vecs[i].exp_char);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Random streams with random gaps and backpressure
    for (int rep = 0; rep < 2; rep++) begin
      int t;
      t = (rep == 0) ? 0 : 3;
      bq.delete(); expq.delete();
      load(t);
      for (int s = 0; s < 60; s++) begin
        int i;
        i = $urandom_range(0, 2);
        expq.push_back(tbls[t].c[i]);
        push_code(t, i);
      end
      budget = 3000;
      while (expq.size() > 0 && budget > 0) begin
        budget--;
        bit_valid  = (bq.size() > 0) && ($urandom_range(0, 3) != 0);
        bit_in     = (bq.size() > 0) ? bq[0] : 1'b0;
        char_ready = ($urandom_range(0, 2) != 0);
        #1;
        acc_now  = bit_valid && bit_ready;
        take_now = char_valid && char_ready;
        chk("rnd_bit_ready", bit_ready, !char_valid || char_ready);
        if (take_now) chk("rnd_char", char_out, expq.pop_front());
        cyc();
        if (acc_now) void'(bq.pop_front());
      end
      bit_valid = 1'b0;
      chk("rnd_drained", expq.size(), 0);
      chk("rnd_err", err, 0);
    end

`ifdef HUFF_DEC_SYMCNT_EN
    char_ready = 1'b1;
    load(0);
    chk("symcnt_load", sym_count, 0);
    bit_valid = 1'b1; bit_in = 1'b0;
    repeat (257) cyc();
    bit_valid = 1'b0;
    cyc();
    chk("symcnt_wrap", sym_count, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("symcnt_reset", sym_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
